// File: rtl/beam_mac_acc.sv
// beam_mac_acc: multi-beat beamforming complex MAC.
// Each RE is GRP beats of ANT complex samples; every beat is weighted by a
// per-beam, per-group code word, summed over antennas and beats, then rounded
// and saturated to OW bits per component for each of BEAM beams.
module beam_mac_acc #(
   parameter int BEAM = 16,
   parameter int ANT  = 16,
   parameter int GRP  = 4,
   parameter int IW   = 32,
   parameter int ACCW = 48,
   parameter int OW   = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_valid,
   input  logic                        i_sop,
   input  logic [ANT*IW-1:0]           i_ants_data,
   input  logic                        i_conj,
   input  logic [5:0]                  i_shift,
   input  logic                        i_cw_wr,
   input  logic [$clog2(BEAM*GRP)-1:0] i_cw_addr,
   input  logic [ANT*IW-1:0]           i_cw_data,
   output logic                        o_valid,
   output logic [BEAM*2*OW-1:0]        o_beam_data,
   output logic                        o_sat,
   output logic                        o_err
);

   localparam int HW  = IW / 2;
   localparam int PW  = IW + 1;
   localparam int NCW = BEAM * GRP;
   localparam int AW  = $clog2(NCW);
   localparam int GW  = (GRP > 1) ? $clog2(GRP) : 1;
   localparam logic [AW:0] NCW_L = (AW+1)'(NCW);
   localparam logic signed [ACCW:0] SAT_MAX = $signed({{(ACCW-OW+2){1'b0}}, {(OW-1){1'b1}}});
   localparam logic signed [ACCW:0] SAT_MIN = $signed({{(ACCW-OW+2){1'b1}}, {(OW-1){1'b0}}});

   typedef enum logic {IDLE, ACC} state_t;

   // Full-precision complex product, optionally against the conjugated code word.
   function automatic logic [2*PW-1:0] cmul(input logic [IW-1:0] x, input logic [IW-1:0] c,
                                            input logic cj);
      logic signed [HW-1:0] xi, xq, ci, cq;
      logic signed [IW-1:0] p_ii, p_qq, p_iq, p_qi;
      logic signed [PW-1:0] pi, pq;
      xi   = x[IW-1:HW];
      xq   = x[HW-1:0];
      ci   = c[IW-1:HW];
      cq   = c[HW-1:0];
      p_ii = IW'(xi) * IW'(ci);
      p_qq = IW'(xq) * IW'(cq);
      p_iq = IW'(xi) * IW'(cq);
      p_qi = IW'(xq) * IW'(ci);
      if (cj) begin
         pi = PW'(p_ii) + PW'(p_qq);
         pq = PW'(p_qi) - PW'(p_iq);
      end else begin
         pi = PW'(p_ii) - PW'(p_qq);
         pq = PW'(p_iq) + PW'(p_qi);
      end
      return {pi, pq};
   endfunction

   // Round half up by 2^(sh-1), arithmetic shift, clip; MSB of result flags clipping.
   function automatic logic [OW:0] rnd_sat(input logic signed [ACCW-1:0] v, input logic [5:0] sh);
      logic signed [ACCW:0] t;
      t = {v[ACCW-1], v};
      if (sh != 6'd0) t = t + ((ACCW+1)'(1) << (sh - 6'd1));
      t = t >>> sh;
      if (t > SAT_MAX) return {1'b1, SAT_MAX[OW-1:0]};
      if (t < SAT_MIN) return {1'b1, SAT_MIN[OW-1:0]};
      return {1'b0, t[OW-1:0]};
   endfunction

   state_t           state, state_nx;
   logic [GW-1:0]    grp, grp_nx, gsel;
   logic             take, beat_first, beat_last, err;
   logic             conj_r, conj_b;
   logic [5:0]       shift_r, shift_b;
   logic [ANT*IW-1:0] bank [NCW];

   logic             vld_p0, err_p0, first_p0, last_p0, conj_p0;
   logic [5:0]       shift_p0;
   logic [ANT*IW-1:0] x_p0;
   logic [ANT*IW-1:0] cw_p0 [BEAM];

   logic             vld_p1, first_p1, last_p1;
   logic [5:0]       shift_p1;
   logic signed [PW-1:0] pi_p1 [BEAM][ANT];
   logic signed [PW-1:0] pq_p1 [BEAM][ANT];

   logic             vld_p2, first_p2, last_p2;
   logic [5:0]       shift_p2;
   logic signed [ACCW-1:0] sum_i [BEAM], sum_q [BEAM];
   logic signed [ACCW-1:0] sum_i_p2 [BEAM], sum_q_p2 [BEAM];

   logic             vld_p3, last_p3;
   logic [5:0]       shift_p3;
   logic signed [ACCW-1:0] acc_i_p3 [BEAM], acc_q_p3 [BEAM];

   logic [BEAM*2*OW-1:0] out_nx;
   logic             sat_nx;
   logic [OW:0]      ri, rq;

   // Framing decision for the beat on the inputs this cycle.
   always_comb begin
      state_nx   = state;
      grp_nx     = grp;
      take       = 1'b0;
      beat_first = 1'b0;
      beat_last  = 1'b0;
      err        = 1'b0;
      if (i_valid) begin
         if (i_sop) begin
            take       = 1'b1;
            beat_first = 1'b1;
            err        = (state == ACC);
            if (GRP == 1) begin
               beat_last = 1'b1;
               state_nx  = IDLE;
               grp_nx    = '0;
            end else begin
               state_nx = ACC;
               grp_nx   = GW'(1);
            end
         end else if (state == ACC) begin
            take = 1'b1;
            if (grp == GW'(GRP-1)) begin
               beat_last = 1'b1;
               state_nx  = IDLE;
               grp_nx    = '0;
            end else begin
               grp_nx = grp + GW'(1);
            end
         end else begin
            err = 1'b1;
         end
      end
   end

   assign gsel    = beat_first ? '0 : grp;
   assign conj_b  = beat_first ? i_conj : conj_r;
   assign shift_b = beat_first ? i_shift : shift_r;

   // Framing state plus per-RE conj/shift captured on the SOP beat.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         grp     <= '0;
         conj_r  <= 1'b0;
         shift_r <= '0;
      end else begin
         state <= state_nx;
         grp   <= grp_nx;
         if (take && beat_first) begin
            conj_r  <= i_conj;
            shift_r <= i_shift;
         end
      end
   end

   // Code-word bank; out-of-range addresses are dropped.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int k = 0; k < NCW; k++) bank[k] <= '0;
      end else if (i_cw_wr && ({1'b0, i_cw_addr} < NCW_L)) begin
         bank[i_cw_addr] <= i_cw_data;
      end
   end

   // Stage p0: capture accepted beat and this group's code words for all beams.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         vld_p0 <= 1'b0;
         err_p0 <= 1'b0;
      end else begin
         vld_p0 <= take;
         err_p0 <= err;
      end
      if (take) begin
         first_p0 <= beat_first;
         last_p0  <= beat_last;
         conj_p0  <= conj_b;
         shift_p0 <= shift_b;
         x_p0     <= i_ants_data;
         for (int b = 0; b < BEAM; b++) cw_p0[b] <= bank[AW'(b*GRP) + AW'(gsel)];
      end
   end

   // Stage p1: per-antenna complex products.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) vld_p1 <= 1'b0;
      else          vld_p1 <= vld_p0;
      if (vld_p0) begin
         first_p1 <= first_p0;
         last_p1  <= last_p0;
         shift_p1 <= shift_p0;
         for (int b = 0; b < BEAM; b++)
            for (int a = 0; a < ANT; a++)
               {pi_p1[b][a], pq_p1[b][a]} <= cmul(x_p0[IW*a +: IW], cw_p0[b][IW*a +: IW], conj_p0);
      end
   end

   // Antenna reduction tree, sign-extended to accumulator width.
   always_comb begin
      for (int b = 0; b < BEAM; b++) begin
         sum_i[b] = '0;
         sum_q[b] = '0;
         for (int a = 0; a < ANT; a++) begin
            sum_i[b] = sum_i[b] + ACCW'(pi_p1[b][a]);
            sum_q[b] = sum_q[b] + ACCW'(pq_p1[b][a]);
         end
      end
   end

   // Stage p2: antenna sums.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) vld_p2 <= 1'b0;
      else          vld_p2 <= vld_p1;
      if (vld_p1) begin
         first_p2 <= first_p1;
         last_p2  <= last_p1;
         shift_p2 <= shift_p1;
         sum_i_p2 <= sum_i;
         sum_q_p2 <= sum_q;
      end
   end

   // Stage p3: beat accumulation; the first beat of an RE reloads.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) vld_p3 <= 1'b0;
      else          vld_p3 <= vld_p2;
      if (vld_p2) begin
         last_p3  <= last_p2;
         shift_p3 <= shift_p2;
         for (int b = 0; b < BEAM; b++) begin
            acc_i_p3[b] <= first_p2 ? sum_i_p2[b] : acc_i_p3[b] + sum_i_p2[b];
            acc_q_p3[b] <= first_p2 ? sum_q_p2[b] : acc_q_p3[b] + sum_q_p2[b];
         end
      end
   end

   // Round/saturate every beam component and collect the clip flag.
   always_comb begin
      out_nx = '0;
      sat_nx = 1'b0;
      ri     = '0;
      rq     = '0;
      for (int b = 0; b < BEAM; b++) begin
         ri = rnd_sat(acc_i_p3[b], shift_p3);
         rq = rnd_sat(acc_q_p3[b], shift_p3);
         out_nx[2*OW*b +: 2*OW] = {ri[OW-1:0], rq[OW-1:0]};
         sat_nx = sat_nx | ri[OW] | rq[OW];
      end
   end

   // Output stage: result registered on the last beat only, held otherwise.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_valid     <= 1'b0;
         o_err       <= 1'b0;
         o_beam_data <= '0;
         o_sat       <= 1'b0;
      end else begin
         o_valid <= vld_p3 & last_p3;
         o_err   <= err_p0;
         if (vld_p3 && last_p3) begin
            o_beam_data <= out_nx;
            o_sat       <= sat_nx;
         end
      end
   end

endmodule

// File: tb/tb_beam_mac_acc.sv
// Bench for beam_mac_acc: constant-vector table, directed framing/bank/reset
// sequences and randomized REs, all scored against a plain-arithmetic model.
module tb_beam_mac_acc;

   localparam int BEAM = 16, ANT = 16, GRP = 4, IW = 32, ACCW = 48, OW = 16;
   localparam int NCW  = BEAM * GRP;
   localparam int AW   = $clog2(NCW);
   localparam int DW   = BEAM * 2 * OW;
   localparam int MAXC = 4096;

   logic              i_clk = 1'b0;
   logic              i_rst_n, i_valid, i_sop, i_conj, i_cw_wr;
   logic [5:0]        i_shift;
   logic [AW-1:0]     i_cw_addr;
   logic [ANT*IW-1:0] i_ants_data, i_cw_data;
   logic              o_valid, o_sat, o_err;
   logic [DW-1:0]     o_beam_data;

   always #5 i_clk = ~i_clk;

   beam_mac_acc #(.BEAM(BEAM), .ANT(ANT), .GRP(GRP), .IW(IW), .ACCW(ACCW), .OW(OW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_sop(i_sop),
      .i_ants_data(i_ants_data), .i_conj(i_conj), .i_shift(i_shift),
      .i_cw_wr(i_cw_wr), .i_cw_addr(i_cw_addr), .i_cw_data(i_cw_data),
      .o_valid(o_valid), .o_beam_data(o_beam_data), .o_sat(o_sat), .o_err(o_err)
   );

   typedef struct {
      int xi; int xq; int ci; int cq; bit cj; int sh; int ei; int eq; bit es;
   } vec_t;

   int checks = 0, failures = 0, cyc = 0;

   // stimulus scratch: current beat data and code word for writes
   int bxi [ANT], bxq [ANT], wci [ANT], wcq [ANT];

   // reference model state
   int     bank_i [NCW][ANT], bank_q [NCW][ANT];
   bit     m_in_re, m_conj;
   int     m_cnt, m_shift;
   longint m_acc_i [BEAM], m_acc_q [BEAM];
   bit     exp_vld [MAXC], exp_sat [MAXC], exp_err [MAXC];
   logic [DW-1:0] exp_data [MAXC];
   logic [DW-1:0] last_data = '0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, exp);
      end
   endtask

   function automatic int rs(input longint v, input int sh, output bit clip);
      longint t;
      t = v;
      if (sh > 0) t = t + (longint'(1) << (sh - 1));
      t = t >>> sh;
      clip = 1'b0;
      if (t > 32767) begin clip = 1'b1; t = 32767; end
      else if (t < -32768) begin clip = 1'b1; t = -32768; end
      return int'(t);
   endfunction

   function automatic int rnd16();
      logic [15:0] r;
      r = 16'($urandom);
      return int'($signed(r));
   endfunction

   function automatic logic [DW-1:0] beam_vec(input int ei, input int eq);
      logic [DW-1:0] v;
      logic [15:0] a, q;
      a = ei[15:0];
      q = eq[15:0];
      for (int b = 0; b < BEAM; b++) v[2*OW*b +: 2*OW] = {a, q};
      return v;
   endfunction

   task automatic add_beat(input int g);
      for (int b = 0; b < BEAM; b++)
         for (int a = 0; a < ANT; a++) begin
            longint xi, xq, ci, cq;
            xi = bxi[a]; xq = bxq[a];
            ci = bank_i[b*GRP+g][a]; cq = bank_q[b*GRP+g][a];
            if (!m_conj) begin
               m_acc_i[b] += xi*ci - xq*cq;
               m_acc_q[b] += xi*cq + xq*ci;
            end else begin
               m_acc_i[b] += xi*ci + xq*cq;
               m_acc_q[b] += xq*ci - xi*cq;
            end
         end
   endtask

   task automatic finish_re(input int e);
      logic [DW-1:0] v;
      bit s, c1, c2;
      int ri, rq;
      s = 1'b0;
      for (int b = 0; b < BEAM; b++) begin
         ri = rs(m_acc_i[b], m_shift, c1);
         rq = rs(m_acc_q[b], m_shift, c2);
         v[2*OW*b +: 2*OW] = {ri[15:0], rq[15:0]};
         s = s | c1 | c2;
      end
      if (e + 4 < MAXC) begin
         exp_vld[e+4]  = 1'b1;
         exp_data[e+4] = v;
         exp_sat[e+4]  = s;
      end
   endtask

   // drive one cycle of inputs (at negedge) and advance the model for the coming edge
   task automatic drive(input bit v, input bit sop, input bit cj, input int sh,
                        input bit wr, input int waddr, input bit rstl);
      int e;
      @(negedge i_clk);
      i_rst_n   = !rstl;
      i_valid   = v;
      i_sop     = sop;
      i_conj    = cj;
      i_shift   = 6'(sh);
      i_cw_wr   = wr;
      i_cw_addr = AW'(waddr);
      for (int a = 0; a < ANT; a++) begin
         i_ants_data[IW*a +: IW] = {bxi[a][15:0], bxq[a][15:0]};
         i_cw_data[IW*a +: IW]   = {wci[a][15:0], wcq[a][15:0]};
      end
      e = cyc + 1;
      if (rstl) begin
         for (int k = 0; k < NCW; k++)
            for (int a = 0; a < ANT; a++) begin bank_i[k][a] = 0; bank_q[k][a] = 0; end
         m_in_re = 1'b0;
         m_cnt   = 0;
         for (int c = e; c < MAXC; c++) begin exp_vld[c] = 1'b0; exp_err[c] = 1'b0; end
      end else begin
         if (v) begin
            if (sop) begin
               if (m_in_re && e + 1 < MAXC) exp_err[e+1] = 1'b1;
               m_conj  = cj;
               m_shift = sh;
               m_in_re = 1'b1;
               for (int b = 0; b < BEAM; b++) begin m_acc_i[b] = 0; m_acc_q[b] = 0; end
               add_beat(0);
               m_cnt = 1;
            end else if (!m_in_re) begin
               if (e + 1 < MAXC) exp_err[e+1] = 1'b1;
            end else begin
               add_beat(m_cnt);
               m_cnt++;
            end
            if (m_in_re && m_cnt == GRP) begin
               finish_re(e);
               m_in_re = 1'b0;
            end
         end
         if (wr && waddr < NCW)
            for (int a = 0; a < ANT; a++) begin bank_i[waddr][a] = wci[a]; bank_q[waddr][a] = wcq[a]; end
      end
   endtask

   task automatic idle();
      drive(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) idle();
   endtask

   task automatic set_x(input int xi, input int xq);
      for (int a = 0; a < ANT; a++) begin bxi[a] = xi; bxq[a] = xq; end
   endtask

   task automatic set_c(input int ci, input int cq);
      for (int a = 0; a < ANT; a++) begin wci[a] = ci; wcq[a] = cq; end
   endtask

   task automatic load_all();
      for (int k = 0; k < NCW; k++) drive(1'b0, 1'b0, 1'b0, 0, 1'b1, k, 1'b0);
   endtask

   task automatic send_re(input bit cj, input int sh, input int gapmax, output int last_e);
      for (int g = 0; g < GRP; g++) begin
         repeat ($urandom_range(0, gapmax)) idle();
         drive(1'b1, g == 0, cj, sh, 1'b0, 0, 1'b0);
         last_e = cyc + 1;
      end
   endtask

   // scoreboard: every cycle, 2 ns after the edge
   initial begin
      forever begin
         @(posedge i_clk);
         cyc++;
         #2;
         if (!i_rst_n) begin
            chk1("rst_valid", o_valid, 1'b0);
            chk1("rst_err", o_err, 1'b0);
            chk1("rst_sat", o_sat, 1'b0);
            chk("rst_data", o_beam_data, '0);
            last_data = '0;
         end else if (cyc < MAXC) begin
            chk1("sb_valid", o_valid, exp_vld[cyc]);
            chk1("sb_err", o_err, exp_err[cyc]);
            if (exp_vld[cyc]) begin
               chk("sb_data", o_beam_data, exp_data[cyc]);
               chk1("sb_sat", o_sat, exp_sat[cyc]);
               last_data = exp_data[cyc];
            end else begin
               chk("sb_hold", o_beam_data, last_data);
            end
         end
      end
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [10];
      int   le;
      i_rst_n = 1'b0; i_valid = 1'b0; i_sop = 1'b0; i_conj = 1'b0; i_shift = '0;
      i_cw_wr = 1'b0; i_cw_addr = '0; i_ants_data = '0; i_cw_data = '0;
      set_x(0, 0);
      set_c(0, 0);

      tbl[0] = '{1, 0, 1, 0, 1'b0, 0, 64, 0, 1'b0};
      tbl[1] = '{0, 1, 0, 1, 1'b0, 0, -64, 0, 1'b0};
      tbl[2] = '{0, 1, 0, 1, 1'b1, 0, 64, 0, 1'b0};
      tbl[3] = '{1, 0, 1, 0, 1'b0, 7, 1, 0, 1'b0};
      tbl[4] = '{32767, 0, 32767, 0, 1'b0, 0, 32767, 0, 1'b1};
      tbl[5] = '{-32768, 0, 32767, 0, 1'b0, 0, -32768, 0, 1'b1};
      tbl[6] = '{3, -2, 5, 7, 1'b0, 0, 1856, 704, 1'b0};
      tbl[7] = '{3, -2, 5, 7, 1'b1, 0, 64, -1984, 1'b0};
      tbl[8] = '{3, -2, 5, 7, 1'b0, 4, 116, 44, 1'b0};
      tbl[9] = '{-1, 0, 1, 0, 1'b0, 6, -1, 0, 1'b0};

      repeat (3) drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);

      // constant vectors: uniform data/code words, all beams identical
      for (int k = 0; k < 10; k++) begin
         set_c(tbl[k].ci, tbl[k].cq);
         load_all();
         set_x(tbl[k].xi, tbl[k].xq);
         send_re(tbl[k].cj, tbl[k].sh, 0, le);
         wait_until(le + 4);
         chk1("tbl_valid", o_valid, 1'b1);
         chk("tbl_data", o_beam_data, beam_vec(tbl[k].ei, tbl[k].eq));
         chk1("tbl_sat", o_sat, tbl[k].es);
      end

      // stray beat in IDLE
      set_c(1, 0);
      load_all();
      set_x(1, 0);
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      le = cyc + 1;
      wait_until(le + 1);
      chk1("stray_err", o_err, 1'b1);
      wait_until(le + 4);
      chk1("stray_novalid", o_valid, 1'b0);

      // SOP after two beats: only the restarted RE comes out
      drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      set_x(2, 0);
      send_re(1'b0, 0, 0, le);
      wait_until(le + 4);
      chk1("restart_valid", o_valid, 1'b1);
      chk("restart_data", o_beam_data, beam_vec(128, 0));

      // gaps between beats
      set_x(1, 0);
      send_re(1'b0, 0, 3, le);
      wait_until(le + 4);
      chk("gap_data", o_beam_data, beam_vec(64, 0));

      // bank write between beats 1 and 2 for beam 3
      drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      set_c(5, 0);
      drive(1'b0, 1'b0, 1'b0, 0, 1'b1, 3*GRP+2, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      le = cyc + 1;
      wait_until(le + 4);
      chk("bankwr_beam3", o_beam_data[2*OW*3 +: 2*OW], 32'h0080_0000);
      chk("bankwr_beam0", o_beam_data[0 +: 2*OW], 32'h0040_0000);

      // reset mid-RE: nothing emerges, then a fresh RE sees a cleared bank
      drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
      repeat (8) idle();
      chk1("rstmid_valid", o_valid, 1'b0);
      chk("rstmid_data", o_beam_data, '0);
      set_x(7, 3);
      send_re(1'b0, 0, 0, le);
      wait_until(le + 4);
      chk1("postrst_valid", o_valid, 1'b1);
      chk("postrst_data", o_beam_data, '0);

      // randomized traffic
      for (int k = 0; k < NCW; k++) begin
         for (int a = 0; a < ANT; a++) begin wci[a] = rnd16(); wcq[a] = rnd16(); end
         drive(1'b0, 1'b0, 1'b0, 0, 1'b1, k, 1'b0);
      end
      for (int re = 0; re < 60; re++) begin
         bit cj;
         int sh;
         cj = 1'($urandom % 2);
         sh = $urandom_range(12, 32);
         if ($urandom % 8 == 0) begin
            for (int a = 0; a < ANT; a++) begin bxi[a] = rnd16(); bxq[a] = rnd16(); end
            drive(1'b1, 1'b0, 1'($urandom % 2), $urandom_range(0, 32), 1'b0, 0, 1'b0);
         end
         for (int g = 0; g < GRP; g++) begin
            repeat ($urandom % 3) begin
               if ($urandom % 5 == 0) begin
                  for (int a = 0; a < ANT; a++) begin wci[a] = rnd16(); wcq[a] = rnd16(); end
                  drive(1'b0, 1'b0, 1'b0, 0, 1'b1, $urandom_range(0, NCW-1), 1'b0);
               end else begin
                  idle();
               end
            end
            for (int a = 0; a < ANT; a++) begin bxi[a] = rnd16(); bxq[a] = rnd16(); end
            if (g == 0) drive(1'b1, 1'b1, cj, sh, 1'b0, 0, 1'b0);
            else        drive(1'b1, 1'b0, 1'($urandom % 2), $urandom_range(0, 32), 1'b0, 0, 1'b0);
            if (g == 1 && $urandom % 10 == 0) break;
         end
      end
      repeat (10) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
